// File: rtl/reg_file_pkg.sv
// Shared encodings and default geometry for the register file
// and its read-side dump streamer.
package reg_file_pkg;

    localparam int RF_W = 5;
    localparam int RF_B = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SEND,
        ST_DONE,
        ST_CSUM
    } dump_state_t;

endpackage

// File: rtl/reg_file_dump.sv
// Register file read-port streamer: walks start..end (mod 2^W) onto a valid/ready stream.
// Optional trailing XOR checksum beat when REG_FILE_DUMP_CSUM_EN is defined.
module reg_file_dump
    import reg_file_pkg::*;
#(
    parameter int W = RF_W,
    parameter int B = RF_B
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         start,
    input  logic [W-1:0] start_addr,
    input  logic [W-1:0] end_addr,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] rd_addr,
    input  logic [B-1:0] rd_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [B-1:0] m_data,
    output logic [W-1:0] m_addr,
    output logic         m_last
);

    dump_state_t  state_q;
    dump_state_t  state_d;
    logic [W-1:0] end_q;
    logic         hs;
    logic         at_end;

`ifdef REG_FILE_DUMP_CSUM_EN
    logic [B-1:0] csum;
`endif

    assign hs     = m_valid & m_ready;
    assign at_end = (m_addr == end_q);
    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_DONE);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (start) state_d = ST_FETCH;
            ST_FETCH: state_d = ST_SEND;
            ST_SEND: begin
                if (hs) begin
`ifdef REG_FILE_DUMP_CSUM_EN
                    state_d = at_end ? ST_CSUM : ST_FETCH;
`else
                    state_d = at_end ? ST_DONE : ST_FETCH;
`endif
                end
            end
`ifdef REG_FILE_DUMP_CSUM_EN
            ST_CSUM:  if (hs) state_d = ST_DONE;
`endif
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            rd_addr <= '0;
            end_q   <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_addr  <= '0;
            m_last  <= 1'b0;
`ifdef REG_FILE_DUMP_CSUM_EN
            csum    <= '0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        rd_addr <= start_addr;
                        end_q   <= end_addr;
`ifdef REG_FILE_DUMP_CSUM_EN
                        csum    <= '0;
`endif
                    end
                end
                ST_FETCH: begin
                    m_data  <= rd_data;
                    m_addr  <= rd_addr;
                    m_valid <= 1'b1;
`ifdef REG_FILE_DUMP_CSUM_EN
                    m_last  <= 1'b0;
`else
                    m_last  <= (rd_addr == end_q);
`endif
                end
                ST_SEND: begin
                    if (hs) begin
                        m_valid <= 1'b0;
`ifdef REG_FILE_DUMP_CSUM_EN
                        csum    <= csum ^ m_data;
                        // Fold the final word in directly so the checksum beat is ready next cycle.
                        if (at_end) begin
                            m_valid <= 1'b1;
                            m_data  <= csum ^ m_data;
                            m_addr  <= '0;
                            m_last  <= 1'b1;
                        end
`endif
                        if (!at_end) begin
                            rd_addr <= rd_addr + W'(1);
                        end
                    end
                end
                ST_CSUM: begin
                    if (hs) begin
                        m_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_dump.sv
// Randomized bench for reg_file_dump against a queue-based beat model.
// Builds with or without REG_FILE_DUMP_CSUM_EN.
module tb_reg_file_dump;

    localparam int W = 5;
    localparam int B = 8;
    localparam int N = 1 << W;

`ifdef REG_FILE_DUMP_CSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         n_reset = 1'b0;
    logic         start = 1'b0;
    logic         m_ready = 1'b0;
    logic [W-1:0] start_addr = '0;
    logic [W-1:0] end_addr = '0;
    logic [W-1:0] rd_addr;
    logic [W-1:0] m_addr;
    logic [B-1:0] rd_data;
    logic [B-1:0] m_data;
    logic         busy;
    logic         done;
    logic         m_valid;
    logic         m_last;

    logic [B-1:0] rf [N];

    typedef struct {
        int addr;
        int data;
        bit last;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    always #5 clk = ~clk;

    assign rd_data = rf[rd_addr];

    reg_file_dump #(.W(W), .B(B)) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .start      (start),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .busy       (busy),
        .done       (done),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_addr     (m_addr),
        .m_last     (m_last)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Beats a dump of s..e must produce, from the address-walk rules alone.
    task automatic build(input int s, input int e);
        int n;
        int x;
        beat_t bt;
        n = ((e - s) % N + N) % N + 1;
        x = 0;
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            bt.addr = (s + k) % N;
            bt.data = bt.addr ^ 'hA5;
            bt.last = !CSUM && (k == n - 1);
            x = x ^ bt.data;
            exp_q.push_back(bt);
        end
        if (CSUM) begin
            bt.addr = 0;
            bt.data = x;
            bt.last = 1'b1;
            exp_q.push_back(bt);
        end
    endtask

    task automatic run_dump(input int s, input int e, input int bp_pct, input int stall_beat);
        int  it;
        int  due;
        int  popped;
        int  stalls;
        bit  seen;
        build(s, e);
        due    = 1 << 30;
        popped = 0;
        stalls = 0;
        seen   = 1'b0;
        @(posedge clk); #1;
        start      = 1'b1;
        start_addr = W'(s);
        end_addr   = W'(e);
        @(posedge clk); #1;
        it = 0;
        while (it <= due + 1 && it < 2000) begin
            if (it > 0) begin
                @(posedge clk); #1;
            end
            start_addr = W'($urandom);
            end_addr   = W'($urandom);
            start      = (due > 100000) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (popped == stall_beat && stalls < 5) begin
                m_ready = 1'b0;
                if (m_valid) stalls++;
            end else begin
                m_ready = ($urandom_range(0, 99) >= bp_pct);
            end
            @(negedge clk);
            chk("busy", busy, it <= due);
            chk("done", done, it == due);
            if (m_valid) begin
                if (!seen) chk("first_valid_cycle", it, 1);
                seen = 1'b1;
                if (exp_q.size() == 0) begin
                    chk("extra_beat", 1, 0);
                end else begin
                    chk("m_addr", m_addr, exp_q[0].addr);
                    chk("m_data", m_data, exp_q[0].data);
                    chk("m_last", m_last, exp_q[0].last);
                    if (m_ready) begin
                        void'(exp_q.pop_front());
                        popped++;
                        if (exp_q.size() == 0) due = it + 1;
                    end
                end
            end
            it++;
        end
        chk("dump_finished", it < 2000, 1);
        chk("beats_left", exp_q.size(), 0);
        start = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) rf[i] = B'(i ^ 'hA5);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_rd_addr", rd_addr, 0);
        n_reset = 1'b1;

        run_dump(3, 6, 0, -1);
        run_dump(30, 1, 0, -1);
        run_dump(10, 14, 0, 1);
        run_dump(7, 7, 0, -1);
        run_dump(0, 31, 0, -1);
        run_dump(5, 4, 30, -1);

        // Abort mid-dump while beat 2 is waiting
        @(posedge clk); #1;
        start = 1'b1; start_addr = 5'd20; end_addr = 5'd25; m_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        @(posedge clk); #1;
        chk("abort_pre_valid", m_valid, 1);
        chk("abort_pre_addr", m_addr, 21);
        n_reset = 1'b0;
        #1;
        chk("abort_m_valid", m_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_m_addr", m_addr, 0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_done", done, 0);
        end
        @(posedge clk); #1;
        n_reset = 1'b1;
        chk("abort_idle_busy", busy, 0);

        run_dump(0, 3, 0, -1);
        run_dump(21, 21, 50, 0);
        repeat (12) begin
            run_dump($urandom_range(0, N - 1), $urandom_range(0, N - 1),
                     $urandom_range(0, 60), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
